qpi_psram_responder: RTL and testbench

- Synthesizable QPI target that emulates the ly68l6400 PSRAM in QPI mode, backed by an internal byte array; it is the device end of the QPI memory controller's bus.
- Used in simulation benches and in loopback FPGA builds that exercise the controller without a physical PSRAM.
- Oversamples the bus on the fabric clock: the QPI clock is treated as data, not as a clock.
- Supports the quad read command with dummy cycles and the quad write command, both with auto-incrementing address.

---
 rtl/qpi_psram_responder.sv | 213 +++++++++++++++++++++
 tb/tb_qpi_psram_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qpi_psram_responder.sv
// QPI PSRAM target (ly68l6400-style quad read/write) backed by an internal byte array.
// The QPI clock is oversampled on the fabric clock and treated as data.
module qpi_psram_responder #(
  parameter logic [7:0]  READCMD   = 8'hEB,
  parameter logic [7:0]  WRITECMD  = 8'h38,
  parameter int unsigned READDUMMY = 7,
  parameter int unsigned AW        = 12
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          qpi_clk_i,
  input  logic          qpi_ncs_i,
  input  logic [3:0]    qpi_sin_i,
  output logic [3:0]    qpi_sout_o,
  output logic          qpi_oe_o,
  output logic          busy_o,
  input  logic [AW-1:0] bd_addr_i,
  output logic [7:0]    bd_rdata_o
);

  localparam int unsigned DW = $clog2(READDUMMY + 1);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StDummy, StRdata, StWdata, StIgnore
  } state_e;

  // [0],[1] synchronizer stages, [2] previous synced value for edge detection
  logic [2:0] qclk_q, ncs_q;
  logic [3:0] sin1_q, sin2_q;

  always_ff @(posedge clk_i) begin
    qclk_q <= {qclk_q[1:0], qpi_clk_i};
    ncs_q  <= {ncs_q[1:0], qpi_ncs_i};
    sin1_q <= qpi_sin_i;
    sin2_q <= sin1_q;
  end

  logic clk_rise, clk_fall, ncs_fall, ncs_hi;
  assign clk_rise = qclk_q[1] & ~qclk_q[2];
  assign clk_fall = ~qclk_q[1] & qclk_q[2];
  assign ncs_fall = ~ncs_q[1] & ncs_q[2];
  assign ncs_hi   = ncs_q[1];

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic [DW-1:0] dcnt_q;
  logic [3:0]    cmd_hi_q;
  logic [AW-1:0] ptr_q;
  logic          mode_rd_q, sel_hi_q, half_q;
  logic [3:0]    wnib_q;
  logic [3:0]    sout_q;
  logic          oe_q, busy_q;

  logic [7:0]    mem_q [2**AW];
  logic [7:0]    rd_byte_q;
  logic [7:0]    bd_rdata_q;

  logic [7:0]    cmd_full;
  logic [AW-1:0] addr_full;
  assign cmd_full  = {cmd_hi_q, sin2_q};
  // ptr_q doubles as the address shift register; only the low AW bits survive
  assign addr_full = {ptr_q[AW-5:0], sin2_q};

  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [7:0]    wr_data;

  always_comb begin
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = ptr_q;
    rd_addr = ptr_q;
    wr_data = {wnib_q, sin2_q};
    if (!rst_i && !ncs_hi) begin
      case (state_q)
        StAddr: begin
          if (clk_rise && cnt_q == 3'd5) begin
            rd_en   = 1'b1;
            rd_addr = addr_full;
          end
        end
        StRdata: begin
          if (clk_fall && !sel_hi_q) begin
            rd_en   = 1'b1;
            rd_addr = ptr_q + AW'(1);
          end
        end
        StWdata: begin
          if (clk_rise && half_q) wr_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_byte_q <= mem_q[rd_addr];
    bd_rdata_q <= mem_q[bd_addr_i];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      dcnt_q    <= '0;
      cmd_hi_q  <= '0;
      ptr_q     <= '0;
      mode_rd_q <= 1'b0;
      sel_hi_q  <= 1'b1;
      half_q    <= 1'b0;
      wnib_q    <= '0;
      sout_q    <= '0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else if (ncs_hi) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      half_q  <= 1'b0;
      oe_q    <= 1'b0;
      sout_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (ncs_fall) begin
            state_q <= StCmd;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        StCmd: begin
          if (clk_rise) begin
            cmd_hi_q <= sin2_q;
            if (cnt_q == 3'd1) begin
              cnt_q <= '0;
              if (cmd_full == READCMD) begin
                state_q   <= StAddr;
                mode_rd_q <= 1'b1;
              end else if (cmd_full == WRITECMD) begin
                state_q   <= StAddr;
                mode_rd_q <= 1'b0;
              end else begin
                state_q <= StIgnore;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        StAddr: begin
          if (clk_rise) begin
            ptr_q <= addr_full;
            if (cnt_q == 3'd5) begin
              cnt_q <= '0;
              if (mode_rd_q) begin
                state_q <= StDummy;
                dcnt_q  <= DW'(READDUMMY);
              end else begin
                state_q <= StWdata;
                half_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        StDummy: begin
          if (clk_rise) begin
            if (dcnt_q == DW'(1)) begin
              state_q  <= StRdata;
              sel_hi_q <= 1'b1;
            end
            dcnt_q <= dcnt_q - DW'(1);
          end
        end
        StRdata: begin
          if (clk_fall) begin
            oe_q <= 1'b1;
            if (sel_hi_q) begin
              sout_q   <= rd_byte_q[7:4];
              sel_hi_q <= 1'b0;
            end else begin
              // the read of ptr+1 issued this cycle lands before the next fall
              sout_q   <= rd_byte_q[3:0];
              sel_hi_q <= 1'b1;
              ptr_q    <= ptr_q + AW'(1);
            end
          end
        end
        StWdata: begin
          if (clk_rise) begin
            if (!half_q) begin
              wnib_q <= sin2_q;
              half_q <= 1'b1;
            end else begin
              half_q <= 1'b0;
              ptr_q  <= ptr_q + AW'(1);
            end
          end
        end
        StIgnore: oe_q <= 1'b0;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign qpi_sout_o = sout_q;
  assign qpi_oe_o   = oe_q;
  assign busy_o     = busy_q;
  assign bd_rdata_o = bd_rdata_q;

endmodule

// File: tb/tb_qpi_psram_responder.sv
// Bench for qpi_psram_responder: directed bus scenarios plus randomized bursts,
// all checked against a byte-array model of the PSRAM.
module tb_qpi_psram_responder;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          qpi_clk = 1'b0;
  logic          qpi_ncs = 1'b1;
  logic [3:0]    qpi_sin = 4'h0;
  logic [3:0]    qpi_sout;
  logic          qpi_oe;
  logic          busy;
  logic [AW-1:0] bd_addr = '0;
  logic [7:0]    bd_rdata;

  qpi_psram_responder #(
    .READCMD   (8'hEB),
    .WRITECMD  (8'h38),
    .READDUMMY (7),
    .AW        (AW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .qpi_clk_i  (qpi_clk),
    .qpi_ncs_i  (qpi_ncs),
    .qpi_sin_i  (qpi_sin),
    .qpi_sout_o (qpi_sout),
    .qpi_oe_o   (qpi_oe),
    .busy_o     (busy),
    .bd_addr_i  (bd_addr),
    .bd_rdata_o (bd_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] model [4096];
  logic [7:0] wq [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // qpi_clk period is 8 fabric clocks: 4 low, 4 high
  task automatic qpulse(input logic [3:0] nib);
    qpi_sin = nib;
    repeat (4) @(negedge clk);
    qpi_clk = 1'b1;
    repeat (4) @(negedge clk);
    qpi_clk = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    qpi_ncs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    qpi_ncs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    qpulse(b[7:4]);
    qpulse(b[3:0]);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    send_byte(cmd);
    for (int i = 5; i >= 0; i--) qpulse(a[i*4 +: 4]);
  endtask

  task automatic bus_write(input logic [23:0] a);
    logic [11:0] idx;
    cs_low();
    send_hdr(8'h38, a);
    for (int i = 0; i < wq.size(); i++) begin
      send_byte(wq[i]);
      idx = a[11:0] + 12'(i);
      model[idx] = wq[i];
    end
    cs_high();
  endtask

  task automatic dummy_phase(input string tag);
    for (int d = 0; d < 7; d++) begin
      qpi_sin = 4'h0;
      repeat (4) @(negedge clk);
      check_eq($sformatf("%s_dummy_oe%0d", tag, d), 32'(qpi_oe), 32'd0);
      qpi_clk = 1'b1;
      repeat (4) @(negedge clk);
      qpi_clk = 1'b0;
    end
  endtask

  // One data nibble: sample just before the rising edge, then clock it.
  task automatic data_pulse(input string tag, input logic [3:0] exp);
    repeat (4) @(negedge clk);
    check_eq($sformatf("%s_sout", tag), 32'(qpi_sout), 32'(exp));
    check_eq($sformatf("%s_oe", tag), 32'(qpi_oe), 32'd1);
    qpi_clk = 1'b1;
    repeat (4) @(negedge clk);
    qpi_clk = 1'b0;
  endtask

  task automatic bus_read_check(input string tag, input logic [23:0] a, input int n);
    logic [11:0] idx;
    logic [7:0]  b;
    cs_low();
    send_hdr(8'hEB, a);
    dummy_phase(tag);
    for (int i = 0; i < 2 * n; i++) begin
      idx = a[11:0] + 12'(i / 2);
      b   = model[idx];
      data_pulse($sformatf("%s_n%0d", tag, i), (i % 2 == 0) ? b[7:4] : b[3:0]);
    end
    cs_high();
  endtask

  task automatic bd_check(input string tag, input logic [11:0] a);
    bd_addr = a;
    repeat (2) @(negedge clk);
    check_eq(tag, 32'(bd_rdata), 32'(model[a]));
  endtask

  initial begin
    logic [23:0] base;
    logic [11:0] upper;
    int len, off;

    repeat (4) @(negedge clk);
    check_eq("rst_oe", 32'(qpi_oe), 32'd0);
    check_eq("rst_sout", 32'(qpi_sout), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Known contents for the window 0xF80..0x07F (wrapping)
    wq.delete();
    for (int i = 0; i < 128; i++) wq.push_back(8'($urandom));
    bus_write(24'h000000);
    wq.delete();
    for (int i = 0; i < 128; i++) wq.push_back(8'($urandom));
    bus_write(24'h000F80);

    // Write nibbles 1..8 at 0x10, then backdoor and bus read-back
    wq.delete();
    wq.push_back(8'h12); wq.push_back(8'h34); wq.push_back(8'h56); wq.push_back(8'h78);
    bus_write(24'h000010);
    for (int i = 0; i < 4; i++) bd_check($sformatf("bd_wr_%0d", i), 12'h010 + 12'(i));
    bus_read_check("rd10", 24'h000010, 4);

    // Wrap-around at the top of the array
    wq.delete();
    wq.push_back(8'hAA); wq.push_back(8'hBB);
    bus_write(24'h000FFF);
    bd_check("bd_wrap_fff", 12'hFFF);
    bd_check("bd_wrap_000", 12'h000);
    bus_read_check("rdwrap", 24'h000FFF, 2);

    // Upper address bits are ignored
    bus_read_check("alias", 24'hABC010, 2);

    // Unknown opcode must leave the array alone and never drive the bus
    cs_low();
    send_byte(8'h9F);
    for (int i = 0; i < 16; i++) begin
      qpi_sin = 4'hF;
      repeat (4) @(negedge clk);
      check_eq($sformatf("ign_oe%0d", i), 32'(qpi_oe), 32'd0);
      qpi_clk = 1'b1;
      repeat (4) @(negedge clk);
      qpi_clk = 1'b0;
    end
    repeat (4) @(negedge clk);
    qpi_ncs = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("ign_busy_drop", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 32; i += 4) bd_check($sformatf("ign_bd_%0d", i), 12'(i));

    // Odd trailing nibble is discarded
    cs_low();
    send_hdr(8'h38, 24'h000020);
    qpulse(4'hC); qpulse(4'hD); qpulse(4'hE);
    model[12'h020] = 8'hCD;
    cs_high();
    bd_check("abort_wr_20", 12'h020);
    bd_check("abort_wr_21", 12'h021);

    // Abort a read after one data nibble
    cs_low();
    send_hdr(8'hEB, 24'h000040);
    dummy_phase("abrd");
    data_pulse("abrd_n0", model[12'h040][7:4]);
    repeat (4) @(negedge clk);
    check_eq("abrd_oe_before", 32'(qpi_oe), 32'd1);
    qpi_ncs = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("abrd_oe_drop", 32'(qpi_oe), 32'd0);
    repeat (8) @(negedge clk);

    // Reset in the middle of a read
    cs_low();
    send_hdr(8'hEB, 24'h000050);
    dummy_phase("rstrd");
    data_pulse("rstrd_n0", model[12'h050][7:4]);
    data_pulse("rstrd_n1", model[12'h050][3:0]);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstrd_oe", 32'(qpi_oe), 32'd0);
    check_eq("rstrd_sout", 32'(qpi_sout), 32'd0);
    check_eq("rstrd_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    qpi_ncs = 1'b1;
    repeat (8) @(negedge clk);
    bus_read_check("postrst", 24'h000050, 4);

    // Randomized write bursts and read-backs inside the known window
    for (int it = 0; it < 64; it++) begin
      len   = $urandom_range(1, 8);
      off   = $urandom_range(0, 256 - len);
      upper = 12'($urandom);
      base  = {upper, 12'hF80 + 12'(off)};
      wq.delete();
      for (int i = 0; i < len; i++) wq.push_back(8'($urandom));
      bus_write(base);
      if (it % 2 == 0) begin
        bus_read_check($sformatf("rnd%0d", it), base, len);
      end else begin
        len = $urandom_range(1, 8);
        off = $urandom_range(0, 256 - len);
        bus_read_check($sformatf("rnd%0d", it), {12'($urandom), 12'hF80 + 12'(off)}, len);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
